lot_input_conditioner: RTL and testbench
========================================

# lot_input_conditioner

Front-end stage for the parking-lot controller. It synchronizes and debounces the raw entry sensor, exit sensor and payment switch, and generates the one-second timebase. Its outputs are the controller's `Ent_Sens`, `Exit_Sens`, `paid_stat` and `Tick_1` inputs. It sits between the board pins and the lot controller in the top level.

## Interface
Parameters:
- `DEB_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz). Legal range is ≥ 2.
- `TICK_DIV`, default 100_000_000: clock cycles per `Tick_1` pulse. Legal range is ≥ 2.

Ports:
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is sampled on `clk`.
- `ent_raw`, input, 1: raw entry sensor, asynchronous to `clk`, bouncy.
- `exit_raw`, input, 1: raw exit sensor, asynchronous, bouncy.
- `pay_raw`, input, 1: raw payment switch, asynchronous, bouncy.
- `Ent_Sens`, output, 1: one-cycle pulse per accepted entry press.
- `Exit_Sens`, output, 1: one-cycle pulse per accepted exit press.
- `paid_stat`, output, 1: debounced level of `pay_raw`.
- `Tick_1`, output, 1: one-cycle pulse every `TICK_DIV` cycles.

## Operation
- **Synchronizer:** each raw input passes through a 2-flop synchronizer. Synchronizer flops reset to 0.
- **Debounce channel:** one identical instance per input. It holds a stable level `deb` and a counter of width `$clog2(DEB_CYCLES)`. The channel FSM has four states:
  - `IDLE`: `deb` = 0.
  - `CONFIRM_HI`: synchronized input has been seen at 1 while `deb` = 0. The counter increments each cycle the sample stays 1.
  - `HELD`: `deb` = 1.
  - `CONFIRM_LO`: the mirror of `CONFIRM_HI`.
- **FSM transitions:**
  - `IDLE`→`CONFIRM_HI` on sample 1, with counter = 1.
  - `CONFIRM_HI`→`HELD` when the sample is 1 and counter = `DEB_CYCLES`-1. This is the `DEB_CYCLES`-th consecutive 1.
  - `CONFIRM_HI`→`IDLE` on any sample 0, with counter cleared. No output change occurs.
  - `HELD`→`CONFIRM_LO`→`IDLE` follows the same rules with polarity inverted.
- **Outputs:**
  - `Ent_Sens` and `Exit_Sens` are registered. They are 1 for exactly the one cycle after their channel enters `HELD`, and 0 otherwise. Release (`HELD`→`IDLE`) produces no pulse.
  - `paid_stat` is the registered `deb` of the pay channel.
- **Independence:** channels are fully independent. Simultaneous entry and exit acceptance yields `Ent_Sens` and `Exit_Sens` high in the same cycle. Arbitration is the controller's job.
- **Tick generator:** a counter of width `$clog2(TICK_DIV)` runs 0..`TICK_DIV`-1 and wraps to 0. `Tick_1` is 1 in the cycle following the counter holding `TICK_DIV`-1. The generator runs free and is unaffected by sensor activity.
- **Reset values:**
  - All outputs are 0.
  - All FSMs are in `IDLE`.
  - All counters and synchronizer flops are 0.
- **Reset mid-operation:** an input still held high after reset release is treated as a new press. It produces a pulse after the full latency. A pulse in flight when reset asserts is dropped.

## Timing
- **Acceptance latency:** from the first `clk` edge that samples a new `*_raw` level, the output reflects it `2 + DEB_CYCLES` edges later. This is 2 cycles of synchronization plus `DEB_CYCLES` cycles of confirmation, with the output register included in the count.
- **Minimum accepted press:** the input must be stable for ≥ `DEB_CYCLES` synchronized samples. A shorter glitch produces no output.
- **Pulse rate:** at most one `Ent_Sens` or `Exit_Sens` pulse per press–release cycle. The minimum spacing between two pulses on the same channel is `2*DEB_CYCLES` cycles.
- **First tick:** `Tick_1` first asserts `TICK_DIV` cycles after reset release. After that it asserts every `TICK_DIV` cycles, with no drift and no skipped wrap.
- **Outputs:** all outputs are registered. There is no combinational path from any input to any output.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `TICK_DIV`=10.
- **Clean press:** hold `ent_raw` 1 for 20 cycles, then release. Required: exactly one `Ent_Sens` pulse, 6 cycles after the first sampled 1. `Exit_Sens` stays 0.
- **Bounce:** toggle `exit_raw` 1,1,0,1,1,1,0, then hold it at 1. Required: no pulse during the toggling. One `Exit_Sens` pulse 6 cycles after the final stable 1 begins. A 3-cycle glitch alone produces no pulse.
- **Pay level:** set `pay_raw` 1 for 10 cycles, then 0. Required: `paid_stat` rises 6 cycles after the rise and falls 6 cycles after the fall. A 2-cycle low glitch while high leaves `paid_stat` at 1.
- **Simultaneous:** `ent_raw` and `exit_raw` rise on the same edge. Required: `Ent_Sens` and `Exit_Sens` both pulse in the same cycle.
- **Tick:** run 35 cycles after reset release. Required: `Tick_1` is high only at cycles 10, 20 and 30, each for one cycle.
- **Reset mid-press:** assert `reset` while `ent_raw` is high in `CONFIRM_HI`, then release with `ent_raw` still high. Required: all outputs go to 0 immediately. One `Ent_Sens` pulse follows 6 cycles after release, and the tick count restarts.

Source files
------------

// File: rtl/lot_input_conditioner.sv
// Parking-lot front end: per-sensor 2-flop sync + debounce FSM, and a free-running 1 s tick.
// Entry/exit channels emit an acceptance pulse; the pay channel exposes its debounced level.

module lot_deb_chan #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter bit PULSE      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic q
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM_HI, HELD, CONFIRM_LO} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          samp;
  logic          deb;
  logic          rise;

  assign samp = sync[1];
  assign q    = PULSE ? rise : deb;

  // deb and rise update on the same edge the FSM enters/leaves HELD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      deb   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      case (state)
        IDLE: if (samp) begin
          state <= CONFIRM_HI;
          cnt   <= CW'(1);
        end
        CONFIRM_HI: begin
          if (!samp) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HELD;
            cnt   <= '0;
            deb   <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: if (!samp) begin
          state <= CONFIRM_LO;
          cnt   <= CW'(1);
        end
        CONFIRM_LO: begin
          if (samp) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            deb   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

module lot_input_conditioner #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TICK_DIV   = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic ent_raw,
  input  logic exit_raw,
  input  logic pay_raw,
  output logic Ent_Sens,
  output logic Exit_Sens,
  output logic paid_stat,
  output logic Tick_1
);
  localparam int NUM_CH = 3;
  localparam logic [NUM_CH-1:0] PULSE_MASK = 3'b011;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

  logic [NUM_CH-1:0] raw_v;
  logic [NUM_CH-1:0] ch_q;
  logic [TW-1:0]     tcnt;

  assign raw_v = {pay_raw, exit_raw, ent_raw};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lot_deb_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .PULSE      (PULSE_MASK[c])
    ) u_chan (
      .clk   (clk),
      .rst_n (reset),
      .raw   (raw_v[c]),
      .q     (ch_q[c])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ent_Sens  <= 1'b0;
      Exit_Sens <= 1'b0;
      paid_stat <= 1'b0;
    end else begin
      Ent_Sens  <= ch_q[0];
      Exit_Sens <= ch_q[1];
      paid_stat <= ch_q[2];
    end
  end

  // Tick fires the cycle after the counter sits at its last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt   <= '0;
      Tick_1 <= 1'b0;
    end else begin
      tcnt   <= (tcnt == TLAST) ? '0 : tcnt + 1'b1;
      Tick_1 <= (tcnt == TLAST);
    end
  end
endmodule

// File: tb/tb_lot_input_conditioner.sv
// Bench for lot_input_conditioner: directed segment table, corner sequences, random stimulus vs window model.

module tb_lot_input_conditioner;
  localparam int DEB  = 4;
  localparam int TDIV = 10;
  localparam int HMAX = 4096;

  logic clk = 1'b0, reset = 1'b0;
  logic ent_raw = 1'b0, exit_raw = 1'b0, pay_raw = 1'b0;
  logic Ent_Sens, Exit_Sens, paid_stat, Tick_1;

  lot_input_conditioner #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .ent_raw   (ent_raw),
    .exit_raw  (exit_raw),
    .pay_raw   (pay_raw),
    .Ent_Sens  (Ent_Sens),
    .Exit_Sens (Exit_Sens),
    .paid_stat (paid_stat),
    .Tick_1    (Tick_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ent; bit ext; bit pay; int len;
    int n_ent; int n_exit; bit paid_end;
  } seg_t;

  int tests = 0, fails = 0;
  bit rh[3][HMAX];           // raw level sampled at each edge since reset release
  bit deb_m[3], rise_m[3];
  int ncyc;
  int ent_cnt, exit_cnt, ent_at, exit_at;
  int paid_rises, paid_up, paid_dn;
  bit paid_prev;
  int tick_cnt;
  int tick_at[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic clear_obs();
    ent_cnt = 0; exit_cnt = 0; ent_at = -1; exit_at = -1;
    paid_rises = 0; paid_up = -1; paid_dn = -1; tick_cnt = 0;
    for (int i = 0; i < 4; i++) tick_at[i] = -1;
  endtask

  task automatic model_reset();
    ncyc = 0; paid_prev = 1'b0;
    for (int c = 0; c < 3; c++) begin deb_m[c] = 1'b0; rise_m[c] = 1'b0; end
  endtask

  // Level flips once the last DEB synchronized samples (raw delayed 2 edges) all differ from it;
  // outputs show the level/flip one edge later.
  task automatic step();
    bit r[3];
    bit exp_lvl[3], exp_pls[3];
    bit flip, s;
    int idx;
    r[0] = ent_raw; r[1] = exit_raw; r[2] = pay_raw;
    @(posedge clk);
    ncyc++;
    for (int c = 0; c < 3; c++) begin
      rh[c][ncyc] = r[c];
      exp_lvl[c] = deb_m[c];
      exp_pls[c] = rise_m[c];
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        idx = ncyc - 2 - j;
        s = (idx >= 1) ? rh[c][idx] : 1'b0;
        if (s == deb_m[c]) flip = 1'b0;
      end
      rise_m[c] = flip && !deb_m[c];
      if (flip) deb_m[c] = !deb_m[c];
    end
    #1;
    check("ent_sens", Ent_Sens, exp_pls[0]);
    check("exit_sens", Exit_Sens, exp_pls[1]);
    check("paid_stat", paid_stat, exp_lvl[2]);
    check("tick_1", Tick_1, (ncyc % TDIV) == 0);
    if (Ent_Sens)  begin ent_cnt++;  ent_at = ncyc;  end
    if (Exit_Sens) begin exit_cnt++; exit_at = ncyc; end
    if (paid_stat && !paid_prev) begin paid_rises++; paid_up = ncyc; end
    if (!paid_stat && paid_prev) paid_dn = ncyc;
    paid_prev = paid_stat;
    if (Tick_1) begin
      if (tick_cnt < 4) tick_at[tick_cnt] = ncyc;
      tick_cnt++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ent"}, Ent_Sens, 0);
    check({tag, "_exit"}, Exit_Sens, 0);
    check({tag, "_paid"}, paid_stat, 0);
    check({tag, "_tick"}, Tick_1, 0);
  endtask

  initial begin
    seg_t tbl[7];
    bit   bp[7];
    int   start, start2;
    int   run[3];
    bit   val[3];

    tbl[0] = '{1'b1, 1'b0, 1'b0, 20, 1, 0, 1'b0};  // clean entry press
    tbl[1] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};  // release: no pulse
    tbl[2] = '{1'b0, 1'b1, 1'b0,  3, 0, 0, 1'b0};  // 3-cycle glitch
    tbl[3] = '{1'b0, 1'b0, 1'b0,  8, 0, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 10, 0, 0, 1'b1};  // pay high
    tbl[5] = '{1'b1, 1'b1, 1'b0, 12, 1, 1, 1'b0};  // simultaneous, pay falls
    tbl[6] = '{1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b0};
    bp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    ncyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    model_reset();

    // free-running tick from release
    clear_obs();
    repeat (35) step();
    check("tick_count", tick_cnt, 3);
    check("tick_at0", tick_at[0], 10);
    check("tick_at1", tick_at[1], 20);
    check("tick_at2", tick_at[2], 30);

    foreach (tbl[i]) begin
      ent_raw = tbl[i].ent; exit_raw = tbl[i].ext; pay_raw = tbl[i].pay;
      clear_obs();
      repeat (tbl[i].len) step();
      check($sformatf("seg%0d_ent_cnt", i), ent_cnt, tbl[i].n_ent);
      check($sformatf("seg%0d_exit_cnt", i), exit_cnt, tbl[i].n_exit);
      check($sformatf("seg%0d_paid", i), paid_stat, tbl[i].paid_end);
    end

    // clean press latency
    clear_obs();
    ent_raw = 1'b1; start = ncyc + 1;
    repeat (20) step();
    ent_raw = 1'b0;
    repeat (10) step();
    check("press_cnt", ent_cnt, 1);
    check("press_lat", ent_at - start, 6);
    check("press_exit", exit_cnt, 0);

    // bounce then stable hold
    clear_obs();
    for (int k = 0; k < 7; k++) begin exit_raw = bp[k]; step(); end
    check("bounce_quiet", exit_cnt, 0);
    exit_raw = 1'b1; start = ncyc + 1;
    repeat (12) step();
    exit_raw = 1'b0;
    repeat (10) step();
    check("bounce_cnt", exit_cnt, 1);
    check("bounce_lat", exit_at - start, 6);

    // pay level rise/fall latency
    clear_obs();
    pay_raw = 1'b1; start = ncyc + 1;
    repeat (10) step();
    pay_raw = 1'b0; start2 = ncyc + 1;
    repeat (10) step();
    check("pay_rise_lat", paid_up - start, 6);
    check("pay_fall_lat", paid_dn - start2, 6);

    // short low glitch while paid
    pay_raw = 1'b1;
    repeat (8) step();
    clear_obs();
    pay_raw = 1'b0;
    repeat (2) step();
    pay_raw = 1'b1;
    repeat (8) step();
    check("pay_glitch_fall", paid_dn, -1);
    check("pay_glitch_lvl", paid_stat, 1);
    pay_raw = 1'b0;
    repeat (10) step();

    // simultaneous acceptance
    clear_obs();
    ent_raw = 1'b1; exit_raw = 1'b1; start = ncyc + 1;
    repeat (12) step();
    ent_raw = 1'b0; exit_raw = 1'b0;
    repeat (10) step();
    check("simul_same_cycle", ent_at, exit_at);
    check("simul_lat", ent_at - start, 6);

    // reset during CONFIRM_HI with pay already accepted
    pay_raw = 1'b1;
    repeat (10) step();
    ent_raw = 1'b1;
    repeat (3) step();
    check("pre_reset_paid", paid_stat, 1);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset = 1'b1;
    model_reset();
    clear_obs();
    repeat (12) step();
    check("rst_press_cnt", ent_cnt, 1);
    check("rst_press_at", ent_at, 7);
    check("rst_tick_at", tick_at[0], 10);
    ent_raw = 1'b0; pay_raw = 1'b0;
    repeat (10) step();

    // random runs of 1..8 cycles per channel
    for (int c = 0; c < 3; c++) begin run[c] = 0; val[c] = 1'b0; end
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          val[c] = 1'($urandom_range(0, 1));
          run[c] = $urandom_range(1, 8);
        end
        run[c]--;
      end
      ent_raw = val[0]; exit_raw = val[1]; pay_raw = val[2];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
